// File: rtl/missile_gen.sv
// Horizontal object generator: per-line position counter, copy/width decode,
// latched horizontal motion, and a registered object pixel for the mixer.
module missile_gen #(
    parameter int unsigned LINE_PIXELS  = 160,
    parameter int unsigned POS_WIDTH    = 8,
    parameter int unsigned SIZE_WIDTH   = 2,
    parameter int unsigned COPY_SPACING = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pixel_en,
    input  logic                  strobe,
    input  logic                  motion_load,
    input  logic [3:0]            motion,
    input  logic                  hmclr,
    input  logic                  hmove,
    input  logic                  enable,
    input  logic [SIZE_WIDTH-1:0] size,
    input  logic [2:0]            copies,
    output logic                  value,
    output logic [POS_WIDTH-1:0]  position
);

    localparam int unsigned RUN_W  = (1 << SIZE_WIDTH) - 1;
    localparam int unsigned RUN_FW = RUN_W + 1;
    localparam int unsigned SUM_W  = POS_WIDTH + 1;

    localparam logic [POS_WIDTH-1:0]    OFF_1S   = POS_WIDTH'(COPY_SPACING);
    localparam logic [POS_WIDTH-1:0]    OFF_2S   = POS_WIDTH'(2 * COPY_SPACING);
    localparam logic [POS_WIDTH-1:0]    OFF_4S   = POS_WIDTH'(4 * COPY_SPACING);
    localparam logic [POS_WIDTH-1:0]    POS_LAST = POS_WIDTH'(LINE_PIXELS - 1);
    localparam logic signed [SUM_W-1:0] LINE_S   = $signed(SUM_W'(LINE_PIXELS));

    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_value;
    logic [RUN_W-1:0]     r_run;
    logic signed [3:0]    r_motreg;

    logic                    w_hit;
    logic signed [SUM_W-1:0] w_sum;
    logic [POS_WIDTH-1:0]    w_hmove_pos;
    logic [POS_WIDTH-1:0]    w_inc_pos;
    logic [RUN_FW-1:0]       w_len_full;
    logic [RUN_W-1:0]        w_run_len;

    logic [POS_WIDTH-1:0] w_pos_nxt;
    logic                 w_value_nxt;
    logic [RUN_W-1:0]     w_run_nxt;
    logic signed [3:0]    w_motreg_nxt;

    // Copy decode: every mode includes offset 0; modes 5 and 7 are single-copy.
    always_comb begin
        w_hit = (r_pos == '0);
        case (copies)
            3'd1:    w_hit = (r_pos == '0) || (r_pos == OFF_1S);
            3'd2:    w_hit = (r_pos == '0) || (r_pos == OFF_2S);
            3'd3:    w_hit = (r_pos == '0) || (r_pos == OFF_1S) || (r_pos == OFF_2S);
            3'd4:    w_hit = (r_pos == '0) || (r_pos == OFF_4S);
            3'd6:    w_hit = (r_pos == '0) || (r_pos == OFF_2S) || (r_pos == OFF_4S);
            default: ;
        endcase
    end

    // Motion-adjusted position, wrapped in either direction around the line.
    always_comb begin
        w_sum = $signed({1'b0, r_pos})
              + $signed({{(SUM_W-4){r_motreg[3]}}, r_motreg})
              + $signed(SUM_W'(pixel_en));
        if (w_sum < 0)
            w_hmove_pos = POS_WIDTH'(w_sum + LINE_S);
        else if (w_sum >= LINE_S)
            w_hmove_pos = POS_WIDTH'(w_sum - LINE_S);
        else
            w_hmove_pos = POS_WIDTH'(w_sum);
    end

    assign w_inc_pos  = (r_pos == POS_LAST) ? '0 : r_pos + POS_WIDTH'(1);
    assign w_len_full = RUN_FW'(1) << size;
    assign w_run_len  = RUN_W'(w_len_full - RUN_FW'(1));

    // Next-state: strobe aborts everything; run only moves on pixel ticks.
    always_comb begin
        w_pos_nxt    = r_pos;
        w_value_nxt  = r_value;
        w_run_nxt    = r_run;
        w_motreg_nxt = r_motreg;

        if (strobe) begin
            w_pos_nxt   = '0;
            w_value_nxt = 1'b0;
            w_run_nxt   = '0;
        end else begin
            if (hmove)
                w_pos_nxt = w_hmove_pos;
            else if (pixel_en)
                w_pos_nxt = w_inc_pos;

            if (pixel_en) begin
                if (!enable) begin
                    w_value_nxt = 1'b0;
                    w_run_nxt   = '0;
                end else if (w_hit) begin
                    w_value_nxt = 1'b1;
                    w_run_nxt   = w_run_len;
                end else if (r_run != '0) begin
                    w_value_nxt = 1'b1;
                    w_run_nxt   = r_run - RUN_W'(1);
                end else begin
                    w_value_nxt = 1'b0;
                end
            end
        end

        if (hmclr)
            w_motreg_nxt = '0;
        else if (motion_load)
            w_motreg_nxt = $signed(motion);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos    <= '0;
            r_value  <= 1'b0;
            r_run    <= '0;
            r_motreg <= '0;
        end else begin
            r_pos    <= w_pos_nxt;
            r_value  <= w_value_nxt;
            r_run    <= w_run_nxt;
            r_motreg <= w_motreg_nxt;
        end
    end

    assign value    = r_value;
    assign position = r_pos;

endmodule
